// File: rtl/shift_req_sequencer.sv
// Issue stage for the multi-stage shifter: buffers tagged requests, drives the shifter from
// registers one request at a time, and returns each captured result on a valid/ready port.
module shift_req_sequencer #(
    parameter int NUM_STAGE  = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4,
    localparam int W         = 2 ** NUM_STAGE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [W-1:0]         req_data,
    input  logic [NUM_STAGE-1:0] req_amt,
    input  logic [1:0]           req_dir,
    input  logic [TAG_W-1:0]     req_tag,
    output logic [W-1:0]         sh_data_in,
    output logic [NUM_STAGE-1:0] sh_cntrl,
    output logic [1:0]           sh_dir,
    input  logic [W-1:0]         sh_data_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [W-1:0]         rsp_data,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic                 rsp_zero,
    output logic                 busy
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int ENT_W = W + NUM_STAGE + 2 + TAG_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CAPT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t               r_state;
    logic [ENT_W-1:0]     r_mem [FIFO_DEPTH];
    logic [AW:0]          r_wr_ptr;
    logic [AW:0]          r_rd_ptr;
    logic [W-1:0]         r_sh_data;
    logic [NUM_STAGE-1:0] r_sh_cntrl;
    logic [1:0]           r_sh_dir;
    logic [TAG_W-1:0]     r_tag;
    logic                 r_rsp_valid;
    logic [W-1:0]         r_rsp_data;
    logic [TAG_W-1:0]     r_rsp_tag;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic [ENT_W-1:0]     w_head;
    logic [W-1:0]         w_head_data;
    logic [NUM_STAGE-1:0] w_head_amt;
    logic [1:0]           w_head_dir;
    logic [TAG_W-1:0]     w_head_tag;
    logic [NUM_STAGE-1:0] w_cntrl;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = req_valid && !w_full;
    assign w_pop   = !w_empty &&
                     ((r_state == S_IDLE) || ((r_state == S_HOLD) && rsp_ready));

    assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
    assign w_head_data = w_head[ENT_W-1 -: W];
    assign w_head_amt  = w_head[TAG_W+2 +: NUM_STAGE];
    assign w_head_dir  = w_head[TAG_W +: 2];
    assign w_head_tag  = w_head[TAG_W-1:0];

    // Stage i shifts by 2**i, so its enable is simply bit i of the amount.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGE; gi++) begin : g_cntrl
            assign w_cntrl[gi] = w_head_amt[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {req_data, req_amt, req_dir, req_tag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sh_data   <= '0;
            r_sh_cntrl  <= '0;
            r_sh_dir    <= '0;
            r_tag       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_tag   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_sh_data  <= w_head_data;
                        r_sh_cntrl <= w_cntrl;
                        r_sh_dir   <= w_head_dir;
                        r_tag      <= w_head_tag;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    r_rsp_data  <= sh_data_out;
                    r_rsp_tag   <= r_tag;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (w_pop) begin
                            r_sh_data  <= w_head_data;
                            r_sh_cntrl <= w_cntrl;
                            r_sh_dir   <= w_head_dir;
                            r_tag      <= w_head_tag;
                            r_state    <= S_ISSUE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = !w_full;
    assign sh_data_in = r_sh_data;
    assign sh_cntrl   = r_sh_cntrl;
    assign sh_dir     = r_sh_dir;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_zero   = (r_rsp_data == '0);
    assign busy       = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_shift_req_sequencer.sv
// Directed bench for shift_req_sequencer with a behavioural shifter on sh_* and an in-order
// scoreboard of expected {result, tag} entries.
module tb_shift_req_sequencer;

    localparam int NS = 3;
    localparam int W  = 8;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_data;
    logic [NS-1:0] req_amt;
    logic [1:0]    req_dir;
    logic [TW-1:0] req_tag;
    logic [W-1:0]  sh_data_in;
    logic [NS-1:0] sh_cntrl;
    logic [1:0]    sh_dir;
    logic [W-1:0]  sh_data_out;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          rsp_zero;
    logic          busy;

    typedef struct {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        n_tests = 0;
    int        n_fail  = 0;
    logic      pushed  = 1'b0;

    always #5 clk = ~clk;

    shift_req_sequencer #(.NUM_STAGE(NS), .FIFO_DEPTH(4), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_amt    (req_amt),
        .req_dir    (req_dir),
        .req_tag    (req_tag),
        .sh_data_in (sh_data_in),
        .sh_cntrl   (sh_cntrl),
        .sh_dir     (sh_dir),
        .sh_data_out(sh_data_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    // Stage-by-stage shifter driven by the DUT's registered controls.
    always_comb begin
        logic [W-1:0] s;
        s = sh_data_in;
        for (int i = 0; i < NS; i++) begin
            if (sh_cntrl[i]) begin
                case (sh_dir)
                    2'b01:   s = s >> (1 << i);
                    2'b10:   s = W'($signed(s) >>> (1 << i));
                    default: s = s << (1 << i);
                endcase
            end
        end
        sh_data_out = s;
    end

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [NS-1:0] a,
                                               input logic [1:0] dir);
        logic signed [W-1:0] sd;
        sd = d;
        case (dir)
            2'b01:   return d >> a;
            2'b10:   return W'(sd >>> a);
            default: return d << a;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // One clock: score a response handshake and record an accepted push, then step past the edge.
    task automatic cycle();
        sb_entry_t e;
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                check("rsp_zero", 32'(rsp_zero), 32'(e.data == '0));
                $display("[TB] rsp tag=%0d data=0x%02h zero=%0b", rsp_tag, rsp_data, rsp_zero);
            end
        end
        pushed = 1'b0;
        if (req_valid && req_ready) begin
            e.data = ref_shift(req_data, req_amt, req_dir);
            e.tag  = req_tag;
            sb.push_back(e);
            pushed = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] d, input logic [NS-1:0] a, input logic [1:0] dir,
                         input logic [TW-1:0] tag);
        req_data  = d;
        req_amt   = a;
        req_dir   = dir;
        req_tag   = tag;
        req_valid = 1'b1;
    endtask

    task automatic push(input logic [W-1:0] d, input logic [NS-1:0] a, input logic [1:0] dir,
                        input logic [TW-1:0] tag);
        drive(d, a, dir, tag);
        cycle();
        req_valid = 1'b0;
        check("push_accepted", 32'(pushed), 32'd1);
    endtask

    task automatic drain(input string name, input int max_cycles);
        for (int k = 0; k < max_cycles && sb.size() > 0; k++) begin
            cycle();
        end
        check(name, sb.size(), 32'd0);
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        for (int k = 0; k < max_cycles && !rsp_valid; k++) begin
            cycle();
        end
        check(name, 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_data  = '0;
        req_amt   = '0;
        req_dir   = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        check("rst_rsp_zero", 32'(rsp_zero), 32'd1);
        check("rst_sh_data", 32'(sh_data_in), 32'd0);
        check("rst_sh_cntrl", 32'(sh_cntrl), 32'd0);
        check("rst_sh_dir", 32'(sh_dir), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: LSL with exact latency
        push(8'h81, 3'd3, 2'b00, 4'd5);
        check("lat_n0", 32'(rsp_valid), 32'd0);
        cycle();
        check("lat_n1", 32'(rsp_valid), 32'd0);
        cycle();
        check("lat_n2", 32'(rsp_valid), 32'd0);
        cycle();
        check("lat_n3_valid", 32'(rsp_valid), 32'd1);
        check("lsl_data", 32'(rsp_data), 32'h08);
        check("lsl_tag", 32'(rsp_tag), 32'd5);
        check("lsl_zero", 32'(rsp_zero), 32'd0);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;

        // 2: LSR, pass-through, zero result
        rsp_ready = 1'b1;
        push(8'h90, 3'd2, 2'b01, 4'd1);
        push(8'hA5, 3'd0, 2'b01, 4'd2);
        push(8'h80, 3'd7, 2'b00, 4'd3);
        drain("drain_t2", 30);
        rsp_ready = 1'b0;

        // 3: fill under backpressure; sixth attempt refused until a slot frees
        for (int k = 0; k < 6; k++) begin
            drive(8'h11 * (k + 1), 3'(k), 2'(k), 4'(k + 1));
            check("full_req_ready", 32'(req_ready), 32'(k < 5));
            if (k < 5) begin
                cycle();
                check("full_push", 32'(pushed), 32'd1);
            end
        end
        cycle();
        check("full_refused", 32'(pushed), 32'd0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 20 && !pushed; k++) begin
            cycle();
        end
        req_valid = 1'b0;
        check("full_sixth_accepted", 32'(pushed), 32'd1);
        drain("drain_t3", 60);
        rsp_ready = 1'b0;

        // 4: push coinciding with a HOLD pop while three entries are queued
        push(8'hC3, 3'd1, 2'b00, 4'd7);
        push(8'h3C, 3'd2, 2'b10, 4'd8);
        push(8'hF0, 3'd3, 2'b01, 4'd9);
        push(8'h96, 3'd4, 2'b11, 4'd10);
        check("conc_hold", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        drive(8'h5A, 3'd5, 2'b10, 4'd11);
        cycle();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("conc_push", 32'(pushed), 32'd1);
        push(8'h0F, 3'd6, 2'b00, 4'd12);
        check("conc_full", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        drain("drain_t4", 60);
        rsp_ready = 1'b0;

        // 5: long stall in HOLD keeps the response and shifter inputs stable
        push(8'h3C, 3'd1, 2'b01, 4'd13);
        push(8'hF0, 3'd4, 2'b10, 4'd14);
        wait_valid("stall_wait", 10);
        for (int k = 0; k < 10; k++) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_data", 32'(rsp_data), 32'h1E);
            check("stall_tag", 32'(rsp_tag), 32'd13);
            check("stall_sh_data", 32'(sh_data_in), 32'h3C);
            cycle();
        end
        rsp_ready = 1'b1;
        drain("drain_t5", 30);
        rsp_ready = 1'b0;

        // 6: reset while capturing with two requests queued
        push(8'h12, 3'd1, 2'b00, 4'd1);
        push(8'h34, 3'd2, 2'b00, 4'd2);
        push(8'h56, 3'd3, 2'b00, 4'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_sh_data", 32'(sh_data_in), 32'd0);
        check("mid_rst_zero", 32'(rsp_zero), 32'd1);
        sb.delete();
        #3 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("post_rst_valid", 32'(rsp_valid), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end
        rsp_ready = 1'b1;
        push(8'hE7, 3'd2, 2'b10, 4'd15);
        drain("drain_t6", 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
